// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell (two half adders
// plus an OR) adds two WIDTH-bit operands LSB first, one bit per clock.
// Start/done handshake; sum/cout are written only when the last bit is done.

module HalfAdder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] ra, rb, rs, rs_n;
  logic             c;
  logic [CW-1:0]    cnt;

  logic ha0_s, ha0_c, fa_sum, ha1_c, fa_cy;
  logic last;

  // Shared 1-bit full adder cell.
  HalfAdder u_ha0 (.x(ra[0]), .y(rb[0]), .s(ha0_s), .c(ha0_c));
  HalfAdder u_ha1 (.x(ha0_s), .y(c),     .s(fa_sum), .c(ha1_c));
  assign fa_cy = ha0_c | ha1_c;

  assign last = (cnt == LAST);
  assign rs_n = {fa_sum, rs[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ADD;
      ADD:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial shift/add, final result write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra   <= '0;
      rb   <= '0;
      rs   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            cnt <= '0;
          end
        end
        ADD: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          rs <= rs_n;
          c  <= fa_cy;
          // Counter returns to 0 on the last bit so it never exceeds WIDTH-1.
          if (last) begin
            cnt  <= '0;
            sum  <= rs_n;
            cout <= fa_cy;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        start8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h want all 0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy16, done16, cout16, sum16} !== 19'd0) begin
      errors++;
      $display("FAIL reset16 got busy=%b done=%b cout=%b sum=%h want all 0", busy16, done16, cout16, sum16);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [8:0] exp, input string name);
    int n;
    bit busy_gap;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = ~av; b8 = ~bv; cin8 = ~ci;
    n = 0;
    busy_gap = 1'b0;
    while (done8 !== 1'b1 && n < 12) begin
      if (busy8 !== 1'b1) busy_gap = 1'b1;
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n !== 8 || busy_gap) begin
      errors++;
      $display("FAIL %s latency got %0d busy_gap=%b want 8 busy_gap=0", name, n, busy_gap);
    end
    checks++;
    if ({cout8, sum8} !== exp || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s result got %h busy=%b want %h busy=0", name, {cout8, sum8}, busy8, exp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || {cout8, sum8} !== exp) begin
      errors++;
      $display("FAIL %s hold got done=%b busy=%b res=%h want 0 0 %h", name, done8, busy8, {cout8, sum8}, exp);
    end
  endtask

  task automatic run_op16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic [16:0] exp, input string name);
    int n;
    @(negedge clk);
    a16 = av; b16 = bv; cin16 = ci; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    a16 = ~av; b16 = ~bv;
    n = 0;
    while (done16 !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n !== 16 || {cout16, sum16} !== exp) begin
      errors++;
      $display("FAIL %s got lat=%0d res=%h want lat=16 res=%h", name, n, {cout16, sum16}, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    run_op8(8'h35, 8'h0A, 1'b0, 9'h03F, "basic");
    run_op8(8'hFF, 8'h00, 1'b1, 9'h100, "ripple1");
    run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "ripple2");
    run_op8(8'h00, 8'h00, 1'b0, 9'h000, "zero");
    run_op16(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "w16_ripple");
    run_op16(16'h1234, 16'h4321, 1'b1, 17'h05556, "w16_basic");
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 a8 = 8'hFF;
    n = 0;
    while (done8 !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (n !== 8 || {cout8, sum8} !== 9'h046) begin
      errors++;
      $display("FAIL ignore_start got lat=%0d res=%h want lat=8 res=046", n, {cout8, sum8});
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy8, done8);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b want 1", busy8);
    end
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 12) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if ({cout8, sum8} !== 9'h133) begin
      errors++;
      $display("FAIL b2b_result got %h want 133", {cout8, sum8});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    bit saw_done;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL post_reset_quiet got activity=1 want 0");
    end
    run_op8(8'h80, 8'h80, 1'b0, 9'h100, "after_reset");
  endtask

  task automatic test_random;
    logic [7:0]  ra8, rb8;
    logic [15:0] ra16, rb16;
    logic        rc;
    for (int i = 0; i < 40; i++) begin
      ra8 = 8'($urandom); rb8 = 8'($urandom); rc = 1'($urandom);
      run_op8(ra8, rb8, rc, {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc}, "rand8");
    end
    for (int i = 0; i < 40; i++) begin
      ra16 = 16'($urandom); rb16 = 16'($urandom); rc = 1'($urandom);
      run_op16(ra16, rb16, rc, {1'b0, ra16} + {1'b0, rb16} + {16'd0, rc}, "rand16");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
